// File: rtl/eth_frame_rewriter.sv
// Ethernet header filter/rewriter: buffers the 14-byte header, decides pass/drop,
// emits a rewritten header, then streams the payload through with no added latency.
module eth_frame_rewriter #(
    parameter logic [47:0] LOCAL_MAC        = 48'h02_00_00_00_00_01,
    parameter int          MODE             = 0,
    parameter int          PROMISC          = 0,
    parameter int          ACCEPT_BCAST     = 1,
    parameter logic [15:0] ETHERTYPE_FILTER = 16'h0000,
    parameter int          COUNT_WIDTH      = 16
) (
    input  logic                   i_clk,
    input  logic                   rst,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic [COUNT_WIDTH-1:0] o_frames_fwd,
    output logic [COUNT_WIDTH-1:0] o_frames_drop
);

    typedef enum logic [2:0] {
        HDR      = 3'd0,
        DECIDE   = 3'd1,
        SEND_HDR = 3'd2,
        PAYLOAD  = 3'd3,
        DROP     = 3'd4
    } state_t;

    localparam logic [3:0]             LAST_IDX = 4'd13;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
    localparam logic [47:0]            BCAST    = 48'hFFFF_FFFF_FFFF;

    state_t                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic [13:0][7:0]        hdr_q, hdr_d;
    logic                    rlast_q, rlast_d;
    logic                    ruser_q, ruser_d;
    logic [COUNT_WIDTH-1:0]  fwd_q, fwd_d;
    logic [COUNT_WIDTH-1:0]  drop_q, drop_d;
    logic                    fwd_inc_s;
    logic                    drop_inc_s;
    logic [47:0]             dest_s;
    logic [15:0]             etype_s;
    logic                    mac_ok_s;
    logic                    type_ok_s;
    logic                    pass_s;

    // Header byte 0 is the first byte on the wire (dest MAC MSB).
    function automatic logic [13:0][7:0] rewrite_hdr(input logic [13:0][7:0] h);
        logic [13:0][7:0] r;
        r = h;
        case (MODE)
            0: begin
                for (int i = 0; i < 6; i++) begin
                    r[i]     = 8'hFF;
                    r[i + 6] = LOCAL_MAC[47 - 8 * i -: 8];
                end
            end
            1: begin
                for (int i = 0; i < 6; i++) begin
                    r[i]     = h[i + 6];
                    r[i + 6] = LOCAL_MAC[47 - 8 * i -: 8];
                end
            end
            default: begin
                r = h;
            end
        endcase
        return r;
    endfunction

    // Filter decision from the captured header.
    always_comb begin
        dest_s    = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
        etype_s   = {hdr_q[12], hdr_q[13]};
        mac_ok_s  = (PROMISC != 0) || (dest_s == LOCAL_MAC) ||
                    ((ACCEPT_BCAST != 0) && (dest_s == BCAST));
        type_ok_s = (ETHERTYPE_FILTER == 16'h0000) || (etype_s == ETHERTYPE_FILTER);
        pass_s    = mac_ok_s && type_ok_s;
    end

    // Next-state, datapath and handshake outputs.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        hdr_d         = hdr_q;
        rlast_d       = rlast_q;
        ruser_d       = ruser_q;
        fwd_inc_s     = 1'b0;
        drop_inc_s    = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        case (state_q)
            HDR: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    hdr_d[idx_q] = s_axis_tdata;
                    if (idx_q == LAST_IDX) begin
                        state_d = DECIDE;
                        idx_d   = 4'd0;
                        rlast_d = s_axis_tlast;
                        ruser_d = s_axis_tuser;
                    end else if (s_axis_tlast) begin
                        drop_inc_s = 1'b1;
                        idx_d      = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            DECIDE: begin
                if (pass_s) begin
                    fwd_inc_s = 1'b1;
                    hdr_d     = rewrite_hdr(hdr_q);
                    state_d   = SEND_HDR;
                end else begin
                    drop_inc_s = 1'b1;
                    state_d    = rlast_q ? HDR : DROP;
                end
            end
            SEND_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_q[idx_q];
                if (idx_q == LAST_IDX) begin
                    m_axis_tlast = rlast_q;
                    m_axis_tuser = rlast_q & ruser_q;
                end else begin
                    m_axis_tlast = 1'b0;
                end
                if (m_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = rlast_q ? HDR : PAYLOAD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            PAYLOAD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = HDR;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = HDR;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = HDR;
                idx_d   = 4'd0;
            end
        endcase
    end

    // Saturating frame counters; the FSM never requests both in one cycle.
    always_comb begin
        if (fwd_inc_s && (fwd_q != CNT_MAX)) begin
            fwd_d = fwd_q + CNT_ONE;
        end else begin
            fwd_d = fwd_q;
        end
        if (drop_inc_s && (drop_q != CNT_MAX)) begin
            drop_d = drop_q + CNT_ONE;
        end else begin
            drop_d = drop_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= HDR;
            idx_q   <= 4'd0;
            hdr_q   <= '{default: 8'h00};
            rlast_q <= 1'b0;
            ruser_q <= 1'b0;
            fwd_q   <= {COUNT_WIDTH{1'b0}};
            drop_q  <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hdr_q   <= hdr_d;
            rlast_q <= rlast_d;
            ruser_q <= ruser_d;
            fwd_q   <= fwd_d;
            drop_q  <= drop_d;
        end
    end

    assign o_frames_fwd  = fwd_q;
    assign o_frames_drop = drop_q;

endmodule

// File: tb/tb_eth_frame_rewriter.sv
// Scoreboard bench: three rewriter instances (MODE 0 defaults, MODE 1 with
// throttled sink, MODE 2 with EtherType filter and 2-bit counters).
`timescale 1ns/1ps
module tb_eth_frame_rewriter;

    localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SMAC = 48'h11_22_33_44_55_66;
    localparam logic [47:0] BMAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] XMAC = 48'h0A_0A_0A_0A_0A_0A;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata [3];
    logic       s_tvalid [3];
    logic       s_tlast [3];
    logic       s_tuser [3];
    logic       m_rdy [3];

    logic [7:0]  m_tdata_a, m_tdata_b, m_tdata_c;
    logic        m_tvalid_a, m_tvalid_b, m_tvalid_c;
    logic        m_tlast_a, m_tlast_b, m_tlast_c;
    logic        m_tuser_a, m_tuser_b, m_tuser_c;
    logic        s_tready_a, s_tready_b, s_tready_c;
    logic [15:0] fwd_a, drop_a, fwd_b, drop_b;
    logic [1:0]  fwd_c, drop_c;

    logic [9:0] exp_q [3][$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    eth_frame_rewriter #(.MODE(0)) dut_a (
        .i_clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready_a),
        .s_axis_tlast(s_tlast[0]), .s_axis_tuser(s_tuser[0]),
        .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_rdy[0]),
        .m_axis_tlast(m_tlast_a), .m_axis_tuser(m_tuser_a),
        .o_frames_fwd(fwd_a), .o_frames_drop(drop_a));

    eth_frame_rewriter #(.MODE(1)) dut_b (
        .i_clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready_b),
        .s_axis_tlast(s_tlast[1]), .s_axis_tuser(s_tuser[1]),
        .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_rdy[1]),
        .m_axis_tlast(m_tlast_b), .m_axis_tuser(m_tuser_b),
        .o_frames_fwd(fwd_b), .o_frames_drop(drop_b));

    eth_frame_rewriter #(.MODE(2), .ETHERTYPE_FILTER(16'h88B5), .COUNT_WIDTH(2)) dut_c (
        .i_clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready_c),
        .s_axis_tlast(s_tlast[2]), .s_axis_tuser(s_tuser[2]),
        .m_axis_tdata(m_tdata_c), .m_axis_tvalid(m_tvalid_c), .m_axis_tready(m_rdy[2]),
        .m_axis_tlast(m_tlast_c), .m_axis_tuser(m_tuser_c),
        .o_frames_fwd(fwd_c), .o_frames_drop(drop_c));

    // Sink readiness: instance b toggles every cycle.
    initial begin
        m_rdy[0] = 1'b1;
        m_rdy[1] = 1'b1;
        m_rdy[2] = 1'b1;
        forever begin
            @(negedge clk);
            m_rdy[1] = ~m_rdy[1];
        end
    end

    // Monitor: pops the scoreboard on every output handshake, checks stall hold.
    initial begin
        logic [7:0] md [3];
        logic       mv [3];
        logic       ml [3];
        logic       mu [3];
        logic       stall [3];
        logic [7:0] pd [3];
        logic       pl [3];
        logic [9:0] e;
        for (int k = 0; k < 3; k++) stall[k] = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            md[0] = m_tdata_a;  md[1] = m_tdata_b;  md[2] = m_tdata_c;
            mv[0] = m_tvalid_a; mv[1] = m_tvalid_b; mv[2] = m_tvalid_c;
            ml[0] = m_tlast_a;  ml[1] = m_tlast_b;  ml[2] = m_tlast_c;
            mu[0] = m_tuser_a;  mu[1] = m_tuser_b;  mu[2] = m_tuser_c;
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    stall[k] = 1'b0;
                end else begin
                    if (stall[k]) begin
                        total++;
                        if (!mv[k] || md[k] != pd[k] || ml[k] != pl[k]) begin
                            bad++;
                            $display("FAIL hold inst%0d: got v=%0b d=%h l=%0b required v=1 d=%h l=%0b",
                                     k, mv[k], md[k], ml[k], pd[k], pl[k]);
                        end
                    end
                    if (mv[k] && m_rdy[k]) begin
                        total++;
                        if (exp_q[k].size() == 0) begin
                            bad++;
                            $display("FAIL unexpected inst%0d: got d=%h l=%0b required no output",
                                     k, md[k], ml[k]);
                        end else begin
                            e = exp_q[k].pop_front();
                            if ({md[k], ml[k], mu[k]} != e) begin
                                bad++;
                                $display("FAIL beat inst%0d: got d=%h l=%0b u=%0b required d=%h l=%0b u=%0b",
                                         k, md[k], ml[k], mu[k], e[9:2], e[1], e[0]);
                            end
                        end
                    end
                    stall[k] = mv[k] && !m_rdy[k];
                    pd[k] = md[k];
                    pl[k] = ml[k];
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic mk(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                      input int plen, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(d[47 - 8 * i -: 8]);
        for (int i = 0; i < 6; i++) q.push_back(s[47 - 8 * i -: 8]);
        q.push_back(t[15:8]);
        q.push_back(t[7:0]);
        for (int i = 0; i < plen; i++) q.push_back(8'(i * 3 + 1));
    endtask

    task automatic push_exp(input int k, input logic [7:0] q[$], input logic usr);
        logic l;
        for (int i = 0; i < q.size(); i++) begin
            l = (i == q.size() - 1);
            exp_q[k].push_back({q[i], l, l & usr});
        end
    endtask

    task automatic send(input int k, input logic [7:0] q[$], input logic usr);
        logic rdy;
        int   i = 0;
        int   guard = 0;
        while (i < q.size()) begin
            @(negedge clk);
            s_tdata[k]  = q[i];
            s_tvalid[k] = 1'b1;
            s_tlast[k]  = (i == q.size() - 1);
            s_tuser[k]  = (i == q.size() - 1) ? usr : 1'b0;
            #2;
            rdy = (k == 0) ? s_tready_a : ((k == 1) ? s_tready_b : s_tready_c);
            if (rdy) i++;
            guard++;
            if (guard > 1000) begin
                total++;
                bad++;
                $display("FAIL send inst%0d: got stalled at byte %0d required accepted", k, i);
                break;
            end
        end
        @(negedge clk);
        s_tvalid[k] = 1'b0;
        s_tlast[k]  = 1'b0;
        s_tuser[k]  = 1'b0;
        s_tdata[k]  = 8'h00;
    endtask

    task automatic drain(input int k);
        int n = 0;
        while (exp_q[k].size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[k].size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain inst%0d: got %0d beats missing required 0", k, exp_q[k].size());
            exp_q[k] = {};
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] f[$];
        logic [7:0] e[$];
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_tdata[k] = 8'h00; s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0; s_tuser[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst tready a", int'(s_tready_a), 1);
        chk("rst tvalid a", int'(m_tvalid_a), 0);
        chk("rst tdata a", int'(m_tdata_a), 0);
        chk("rst fwd a", int'(fwd_a), 0);
        chk("rst drop a", int'(drop_a), 0);
        chk("rst tready c", int'(s_tready_c), 1);
        chk("rst fwd c", int'(fwd_c), 0);
        rst = 1'b0;

        // MODE 0: 60-byte frame to station MAC becomes broadcast from station MAC
        mk(LMAC, SMAC, 16'h0800, 46, f);
        mk(BMAC, LMAC, 16'h0800, 46, e);
        push_exp(0, e, 1'b0);
        send(0, f, 1'b0);
        drain(0);
        chk("a60 fwd", int'(fwd_a), 1);
        chk("a60 drop", int'(drop_a), 0);

        // foreign dest is dropped silently, next valid frame still forwarded
        mk(XMAC, SMAC, 16'h0800, 6, f);
        send(0, f, 1'b0);
        mk(LMAC, SMAC, 16'h0800, 6, f);
        mk(BMAC, LMAC, 16'h0800, 6, e);
        push_exp(0, e, 1'b0);
        send(0, f, 1'b0);
        drain(0);
        chk("afilt drop", int'(drop_a), 1);
        chk("afilt fwd", int'(fwd_a), 2);

        // runt frame then header-only frame carrying tuser
        mk(LMAC, SMAC, 16'h0800, 0, f);
        f = f[0:9];
        send(0, f, 1'b0);
        mk(LMAC, SMAC, 16'h0806, 0, f);
        mk(BMAC, LMAC, 16'h0806, 0, e);
        push_exp(0, e, 1'b1);
        send(0, f, 1'b1);
        drain(0);
        chk("ashort drop", int'(drop_a), 2);
        chk("ashort fwd", int'(fwd_a), 3);

        // broadcast accepted; header-only foreign frame dropped without stalling
        mk(BMAC, SMAC, 16'h0800, 4, f);
        mk(BMAC, LMAC, 16'h0800, 4, e);
        push_exp(0, e, 1'b0);
        send(0, f, 1'b0);
        mk(XMAC, SMAC, 16'h0800, 0, f);
        send(0, f, 1'b0);
        mk(LMAC, SMAC, 16'h0800, 3, f);
        mk(BMAC, LMAC, 16'h0800, 3, e);
        push_exp(0, e, 1'b0);
        send(0, f, 1'b0);
        drain(0);
        chk("abc fwd", int'(fwd_a), 5);
        chk("abc drop", int'(drop_a), 3);

        // MODE 1 with sink ready toggling every cycle
        mk(LMAC, SMAC, 16'h0800, 46, f);
        mk(SMAC, LMAC, 16'h0800, 46, e);
        push_exp(1, e, 1'b0);
        send(1, f, 1'b0);
        drain(1);
        chk("b60 fwd", int'(fwd_b), 1);
        chk("b60 drop", int'(drop_b), 0);

        // EtherType filter and counter saturation (MODE 2 keeps header)
        mk(LMAC, SMAC, 16'h0800, 6, f);
        send(2, f, 1'b0);
        mk(LMAC, SMAC, 16'h88B5, 6, f);
        push_exp(2, f, 1'b0);
        send(2, f, 1'b0);
        drain(2);
        chk("ctype drop", int'(drop_c), 1);
        chk("ctype fwd", int'(fwd_c), 1);
        for (int n = 0; n < 4; n++) begin
            push_exp(2, f, 1'b0);
            send(2, f, 1'b0);
        end
        drain(2);
        chk("csat fwd", int'(fwd_c), 3);
        chk("csat drop", int'(drop_c), 1);

        // reset mid-header abandons the frame and clears counters
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_tdata[0] = 8'hA0 + 8'(i);
            s_tvalid[0] = 1'b1;
        end
        @(negedge clk);
        s_tvalid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst tready", int'(s_tready_a), 1);
        chk("mrst tvalid", int'(m_tvalid_a), 0);
        chk("mrst fwd", int'(fwd_a), 0);
        chk("mrst drop", int'(drop_a), 0);
        rst = 1'b0;
        mk(LMAC, SMAC, 16'h0800, 2, f);
        mk(BMAC, LMAC, 16'h0800, 2, e);
        push_exp(0, e, 1'b0);
        send(0, f, 1'b0);
        drain(0);
        chk("mrst after fwd", int'(fwd_a), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
